// File: rtl/bomb_pkg.sv
// Shared encodings for the bomb game sequencer: game states, module versions,
// default timing, and a small popcount helper for strike aggregation.
package bomb_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_ARMED    = 3'd2;
  localparam logic [2:0] ST_EXPLODED = 3'd3;
  localparam logic [2:0] ST_DEFUSED  = 3'd4;

  typedef enum logic [1:0] {
    VERSION_A = 2'd0,
    VERSION_B = 2'd1,
    VERSION_C = 2'd2,
    VERSION_D = 2'd3
  } version_t;

  localparam int unsigned DEFAULT_TICKS_PER_SEC = 27_000_000;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/countdown_timer.sv
// Countdown timer: prescaler divides the clock down to one tick per second and
// the seconds register counts down from START_SECONDS while run is high.
module countdown_timer
  import bomb_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int unsigned START_SECONDS = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  output logic [9:0] seconds_left,
  output logic       tick,
  output logic       expire
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] prescaler;

  // Tick is combinational so it lines up with the edge that decrements seconds.
  assign tick   = run && (prescaler == P_LAST);
  assign expire = tick && (seconds_left == 10'd1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      prescaler    <= '0;
      seconds_left <= 10'(START_SECONDS);
    end else if (load) begin
      prescaler    <= '0;
      seconds_left <= 10'(START_SECONDS);
    end else if (run) begin
      if (tick) begin
        prescaler <= '0;
        if (seconds_left != '0) begin
          seconds_left <= seconds_left - 10'd1;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bomb_controller.sv
// Game sequencer: configures each puzzle module with a random version, arms
// them, runs the countdown, aggregates strikes and decides the outcome.
module bomb_controller
  import bomb_pkg::*;
#(
  parameter int unsigned NUM_MODULES   = 4,
  parameter int unsigned MAX_STRIKES   = 3,
  parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int unsigned START_SECONDS = 300
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               rng_output,
  input  logic [NUM_MODULES-1:0]   module_strike,
  input  logic [NUM_MODULES-1:0]   module_defused,
  output logic [NUM_MODULES-1:0]   module_enable,
  output logic [NUM_MODULES-1:0]   module_rng_enable,
  output logic [2*NUM_MODULES-1:0] module_version,
  output logic [9:0]               seconds_left,
  output logic [2:0]               strike_count,
  output logic [2:0]               game_state,
  output logic                     tick_1hz,
  output logic                     exploded,
  output logic                     bomb_defused
);

  localparam int unsigned IW = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;

  logic [2:0]             state;
  logic                   start_q;
  logic [IW-1:0]          setup_idx;
  logic [NUM_MODULES-1:0] strike_q;
  logic [NUM_MODULES-1:0] strike_rise;
  logic [3:0]             strike_sum;
  logic [2:0]             strike_next;
  logic                   start_rise;
  logic                   idle_like;
  logic                   armed;
  logic                   timer_load;
  logic                   timer_expire;
  logic                   explode_now;
  logic                   defuse_now;
  logic                   unused_rng_bits;

  assign unused_rng_bits = ^rng_output[3:2];

  assign start_rise = start & ~start_q;
  assign idle_like  = (state == ST_IDLE) || (state == ST_EXPLODED) || (state == ST_DEFUSED);
  assign armed      = (state == ST_ARMED);
  assign timer_load = start_rise && idle_like;

  assign strike_rise = module_strike & ~strike_q;
  assign strike_sum  = {1'b0, strike_count} + popcount8(8'(strike_rise));
  assign strike_next = (strike_sum >= 4'(MAX_STRIKES)) ? 3'(MAX_STRIKES) : strike_sum[2:0];

  // Explosion is checked before defuse so a simultaneous outcome detonates.
  assign explode_now = armed && ((strike_sum >= 4'(MAX_STRIKES)) || timer_expire);
  assign defuse_now  = armed && (&module_defused);

  countdown_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .START_SECONDS(START_SECONDS)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .load        (timer_load),
    .run         (armed),
    .seconds_left(seconds_left),
    .tick        (tick_1hz),
    .expire      (timer_expire)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= ST_IDLE;
      start_q        <= 1'b0;
      setup_idx      <= '0;
      strike_q       <= '0;
      strike_count   <= '0;
      module_version <= '0;
    end else begin
      start_q  <= start;
      strike_q <= module_strike;
      case (state)
        ST_IDLE, ST_EXPLODED, ST_DEFUSED: begin
          if (start_rise) begin
            state        <= ST_SETUP;
            setup_idx    <= '0;
            strike_count <= '0;
          end
        end
        ST_SETUP: begin
          for (int unsigned i = 0; i < NUM_MODULES; i++) begin
            if (setup_idx == IW'(i)) begin
              module_version[2*i +: 2] <= rng_output[1:0];
            end
          end
          if (setup_idx == IW'(NUM_MODULES - 1)) begin
            state     <= ST_ARMED;
            setup_idx <= '0;
          end else begin
            setup_idx <= setup_idx + 1'b1;
          end
        end
        ST_ARMED: begin
          strike_count <= strike_next;
          if (explode_now) begin
            state <= ST_EXPLODED;
          end else if (defuse_now) begin
            state <= ST_DEFUSED;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    module_rng_enable = '0;
    if (state == ST_SETUP) begin
      for (int unsigned i = 0; i < NUM_MODULES; i++) begin
        if (setup_idx == IW'(i)) begin
          module_rng_enable[i] = 1'b1;
        end
      end
    end
  end

  assign module_enable = armed ? '1 : '0;
  assign game_state    = state;
  assign exploded      = (state == ST_EXPLODED);
  assign bomb_defused  = (state == ST_DEFUSED);

endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller with a 4-cycle second and 3-second game.
module tb_bomb_controller;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] rng_output;
  logic [3:0] module_strike;
  logic [3:0] module_defused;
  logic [3:0] module_enable;
  logic [3:0] module_rng_enable;
  logic [7:0] module_version;
  logic [9:0] seconds_left;
  logic [2:0] strike_count;
  logic [2:0] game_state;
  logic       tick_1hz;
  logic       exploded;
  logic       bomb_defused;

  int tests = 0;
  int fails = 0;

  bomb_controller #(
    .NUM_MODULES  (4),
    .MAX_STRIKES  (3),
    .TICKS_PER_SEC(4),
    .START_SECONDS(3)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .rng_output       (rng_output),
    .module_strike    (module_strike),
    .module_defused   (module_defused),
    .module_enable    (module_enable),
    .module_rng_enable(module_rng_enable),
    .module_version   (module_version),
    .seconds_left     (seconds_left),
    .strike_count     (strike_count),
    .game_state       (game_state),
    .tick_1hz         (tick_1hz),
    .exploded         (exploded),
    .bomb_defused     (bomb_defused)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst_n;
    logic       st;
    logic [3:0] rng;
    logic [3:0] strike;
    logic [3:0] defused;
    logic [2:0] exp_state;
    logic [9:0] exp_sec;
    logic [2:0] exp_strikes;
    logic [3:0] exp_en;
    logic [3:0] exp_rngen;
    logic [7:0] exp_ver;
    logic       exp_tick;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [3:0] rng,
                     input logic [2:0] est, input logic [9:0] esec, input logic [3:0] een,
                     input logic [3:0] erng, input logic [7:0] ever, input logic etick);
    vec_t v;
    v.rst_n = r; v.st = s; v.rng = rng; v.strike = 4'h0; v.defused = 4'h0;
    v.exp_state = est; v.exp_sec = esec; v.exp_strikes = 3'd0; v.exp_en = een;
    v.exp_rngen = erng; v.exp_ver = ever; v.exp_tick = etick;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic go_armed(input string tag);
    reset = 1'b0; start = 1'b0; rng_output = 4'b0110;
    module_strike = 4'h0; module_defused = 4'h0;
    step();
    reset = 1'b1;
    step();
    start = 1'b1;
    step();
    check({tag, " setup"}, 32'(game_state), 32'd1);
    start = 1'b0;
    repeat (4) step();
    check({tag, " armed"}, 32'(game_state), 32'd2);
    check({tag, " armed strikes"}, 32'(strike_count), 32'd0);
    check({tag, " armed seconds"}, 32'(seconds_left), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; rng_output = 4'h0;
    module_strike = 4'h0; module_defused = 4'h0;

    // rst start rng | state sec en rngen ver tick
    add(0, 0, 4'h6, 3'd0, 10'd3, 4'h0, 4'h0, 8'h00, 0);
    add(1, 0, 4'h6, 3'd0, 10'd3, 4'h0, 4'h0, 8'h00, 0);
    add(1, 1, 4'h6, 3'd1, 10'd3, 4'h0, 4'h1, 8'h00, 0);
    add(1, 1, 4'h6, 3'd1, 10'd3, 4'h0, 4'h2, 8'h02, 0);
    add(1, 1, 4'h6, 3'd1, 10'd3, 4'h0, 4'h4, 8'h0A, 0);
    add(1, 1, 4'h6, 3'd1, 10'd3, 4'h0, 4'h8, 8'h2A, 0);
    add(1, 1, 4'h6, 3'd2, 10'd3, 4'hF, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h6, 3'd2, 10'd3, 4'hF, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h6, 3'd2, 10'd3, 4'hF, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h6, 3'd2, 10'd3, 4'hF, 4'h0, 8'hAA, 1);
    add(1, 1, 4'h6, 3'd2, 10'd2, 4'hF, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h6, 3'd2, 10'd2, 4'hF, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h6, 3'd2, 10'd2, 4'hF, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h6, 3'd2, 10'd2, 4'hF, 4'h0, 8'hAA, 1);
    add(1, 1, 4'h6, 3'd2, 10'd1, 4'hF, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h6, 3'd2, 10'd1, 4'hF, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h6, 3'd2, 10'd1, 4'hF, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h6, 3'd2, 10'd1, 4'hF, 4'h0, 8'hAA, 1);
    add(1, 1, 4'h6, 3'd3, 10'd0, 4'h0, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h6, 3'd3, 10'd0, 4'h0, 4'h0, 8'hAA, 0);
    add(1, 0, 4'h9, 3'd3, 10'd0, 4'h0, 4'h0, 8'hAA, 0);
    add(1, 1, 4'h9, 3'd1, 10'd3, 4'h0, 4'h1, 8'hAA, 0);
    add(1, 1, 4'h9, 3'd1, 10'd3, 4'h0, 4'h2, 8'hA9, 0);
    add(1, 1, 4'h9, 3'd1, 10'd3, 4'h0, 4'h4, 8'hA5, 0);
    add(1, 1, 4'h9, 3'd1, 10'd3, 4'h0, 4'h8, 8'h95, 0);
    add(1, 1, 4'h9, 3'd2, 10'd3, 4'hF, 4'h0, 8'h55, 0);
    add(0, 0, 4'h9, 3'd0, 10'd3, 4'h0, 4'h0, 8'h00, 0);
    add(1, 0, 4'h9, 3'd0, 10'd3, 4'h0, 4'h0, 8'h00, 0);
    add(1, 1, 4'h3, 3'd1, 10'd3, 4'h0, 4'h1, 8'h00, 0);
    add(1, 1, 4'h3, 3'd1, 10'd3, 4'h0, 4'h2, 8'h03, 0);
    add(0, 0, 4'h3, 3'd0, 10'd3, 4'h0, 4'h0, 8'h00, 0);
    add(1, 0, 4'h3, 3'd0, 10'd3, 4'h0, 4'h0, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst_n; start = vecs[i].st; rng_output = vecs[i].rng;
      module_strike = vecs[i].strike; module_defused = vecs[i].defused;
      step();
      check($sformatf("v%0d state", i), 32'(game_state), 32'(vecs[i].exp_state));
      check($sformatf("v%0d seconds", i), 32'(seconds_left), 32'(vecs[i].exp_sec));
      check($sformatf("v%0d strikes", i), 32'(strike_count), 32'(vecs[i].exp_strikes));
      check($sformatf("v%0d enable", i), 32'(module_enable), 32'(vecs[i].exp_en));
      check($sformatf("v%0d rng_en", i), 32'(module_rng_enable), 32'(vecs[i].exp_rngen));
      check($sformatf("v%0d version", i), 32'(module_version), 32'(vecs[i].exp_ver));
      check($sformatf("v%0d tick", i), 32'(tick_1hz), 32'(vecs[i].exp_tick));
      check($sformatf("v%0d exploded", i), 32'(exploded), 32'(vecs[i].exp_state == 3'd3));
      check($sformatf("v%0d defused", i), 32'(bomb_defused), 32'(vecs[i].exp_state == 3'd4));
    end

    // Sequential strikes; a held strike counts once.
    go_armed("s3");
    module_strike = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("s3 held count", 32'(strike_count), 32'd1);
    end
    module_strike = 4'b0000; step();
    check("s3 release", 32'(strike_count), 32'd1);
    module_strike = 4'b0100; step();
    check("s3 second", 32'(strike_count), 32'd2);
    check("s3 still armed", 32'(game_state), 32'd2);
    module_strike = 4'b0000; step();
    module_strike = 4'b0001; step();
    check("s3 third", 32'(strike_count), 32'd3);
    check("s3 exploded", 32'(game_state), 32'd3);
    repeat (9) step();
    check("s3 held after", 32'(strike_count), 32'd3);
    check("s3 exploded flag", 32'(exploded), 32'd1);
    check("s3 enable off", 32'(module_enable), 32'd0);
    check("s3 timer frozen", 32'(seconds_left), 32'd2);
    check("s3 tick off", 32'(tick_1hz), 32'd0);

    // Two simultaneous rises: 1+2 reaches the limit.
    go_armed("s4a");
    module_strike = 4'b0001; step();
    module_strike = 4'b0000; step();
    check("s4a one", 32'(strike_count), 32'd1);
    module_strike = 4'b1010; step();
    check("s4a pair", 32'(strike_count), 32'd3);
    check("s4a exploded", 32'(game_state), 32'd3);

    // Two simultaneous rises from 2 saturate at 3.
    go_armed("s4b");
    module_strike = 4'b0001; step();
    module_strike = 4'b0000; step();
    module_strike = 4'b0100; step();
    module_strike = 4'b0000; step();
    check("s4b two", 32'(strike_count), 32'd2);
    module_strike = 4'b1010; step();
    check("s4b saturated", 32'(strike_count), 32'd3);
    check("s4b exploded", 32'(game_state), 32'd3);

    // Defuse with 2 s left, partial defuse does nothing.
    go_armed("s5");
    module_defused = 4'b0111;
    repeat (4) step();
    check("s5 partial", 32'(game_state), 32'd2);
    check("s5 two left", 32'(seconds_left), 32'd2);
    module_defused = 4'hF; step();
    check("s5 defused", 32'(game_state), 32'd4);
    check("s5 defused flag", 32'(bomb_defused), 32'd1);
    check("s5 enable off", 32'(module_enable), 32'd0);
    repeat (8) step();
    check("s5 frozen", 32'(seconds_left), 32'd2);
    module_strike = 4'b0001; step();
    check("s5 strike ignored", 32'(strike_count), 32'd0);
    check("s5 still defused", 32'(game_state), 32'd4);

    // Defuse and third strike in the same cycle: explosion wins.
    go_armed("s5b");
    module_strike = 4'b0001; step();
    module_strike = 4'b0000; step();
    module_strike = 4'b0100; step();
    module_strike = 4'b0000; step();
    module_strike = 4'b0001; module_defused = 4'hF; step();
    check("s5b exploded", 32'(game_state), 32'd3);
    check("s5b not defused", 32'(bomb_defused), 32'd0);

    // New game from EXPLODED clears strikes and reloads the timer.
    module_strike = 4'b0000; module_defused = 4'h0; start = 1'b1; step();
    check("s6 restart", 32'(game_state), 32'd1);
    check("s6 seconds", 32'(seconds_left), 32'd3);
    check("s6 strikes", 32'(strike_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
